// File: rtl/decoder_proj_hamming_tx_pkg.sv
// Shared definitions for the decoder_proj Hamming(7,4) transmit path:
// FSM states, the default idle code and the encoder function.
package decoder_proj_hamming_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    localparam logic [6:0] DEFAULT_IDLE_CODE = 7'b0000000;

    // Codeword bit 0 is Hamming position 1: {d3,d2,d1,p4,d0,p2,p1}.
    function automatic logic [6:0] hamming74_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

endpackage

// File: rtl/decoder_proj_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full and count come straight
// from the occupancy register, so a same-cycle pop never frees a slot early.
module decoder_proj_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/decoder_proj_hamming_tx.sv
// Buffers nibbles, Hamming(7,4)-encodes them and holds each codeword on
// code_o for HOLD_CYCLES clocks followed by GAP_CYCLES idle clocks.
module decoder_proj_hamming_tx
    import decoder_proj_hamming_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         HOLD_CYCLES = 8,
    parameter int         GAP_CYCLES  = 2,
    parameter logic [6:0] IDLE_CODE   = DEFAULT_IDLE_CODE
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic [3:0]                      data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [6:0]                      code_o,
    output logic                            code_valid_o,
    output logic                            busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [6:0]       code_q;
    logic [6:0]       code_d;
    logic             valid_q;
    logic             valid_d;
    logic             load_next;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [3:0]       fifo_dout;

    decoder_proj_sync_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (wb_clk_i),
        .reset (wb_rst_i),
        .push  (valid_i && ready_o),
        .pop   (fifo_pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count_o)
    );

    assign ready_o      = !fifo_full;
    assign code_o       = code_q;
    assign code_valid_o = valid_q;
    assign busy_o       = (state_q != IDLE) || !fifo_empty;

    // Every path that starts a new codeword funnels through load_next so
    // IDLE, end-of-GAP and back-to-back HOLD share one pop/encode path.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = valid_q;
        fifo_pop  = 1'b0;
        load_next = 1'b0;
        case (state_q)
            IDLE: load_next = !fifo_empty;
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    code_d  = IDLE_CODE;
                    valid_d = 1'b0;
                end else if (!fifo_empty) begin
                    load_next = 1'b1;
                end else begin
                    state_d = IDLE;
                    code_d  = IDLE_CODE;
                    valid_d = 1'b0;
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!fifo_empty) begin
                    load_next = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = IDLE_CODE;
                valid_d = 1'b0;
            end
        endcase
        if (load_next) begin
            fifo_pop = 1'b1;
            state_d  = HOLD;
            cnt_d    = HOLD_LOAD;
            code_d   = hamming74_encode(fifo_dout);
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= IDLE_CODE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

endmodule
